// File: rtl/prog_seq_if.sv
// Run handshake, branch/call controls, flag and LUT-write bus between the
// control decoder (master) and the program sequencer (slave).
interface prog_seq_if #(
    parameter int D = 12,
    parameter int L = 5
);
    logic         req;
    logic         done;
    logic         busy;
    logic [D-1:0] prog_ctr;
    logic         br_rel;
    logic         br_abs;
    logic [1:0]   br_cond;
    logic [7:0]   rel_off;
    logic [L-1:0] lut_idx;
    logic         call;
    logic         ret;
    logic         zero;
    logic         pari;
    logic         sc_o;
    logic         flag_en;
    logic         sc_clr;
    logic         sc_en;
    logic         zeroQ;
    logic         pariQ;
    logic         sc_q;
    logic         lut_we;
    logic [L-1:0] lut_waddr;
    logic [D-1:0] lut_wdata;
    logic         stk_err;

    modport master (
        output req, br_rel, br_abs, br_cond, rel_off, lut_idx, call, ret,
               zero, pari, sc_o, flag_en, sc_clr, sc_en,
               lut_we, lut_waddr, lut_wdata,
        input  done, busy, prog_ctr, zeroQ, pariQ, sc_q, stk_err
    );

    modport slave (
        input  req, br_rel, br_abs, br_cond, rel_off, lut_idx, call, ret,
               zero, pari, sc_o, flag_en, sc_clr, sc_en,
               lut_we, lut_waddr, lut_wdata,
        output done, busy, prog_ctr, zeroQ, pariQ, sc_q, stk_err
    );
endinterface

// File: rtl/prog_seq.sv
// Program sequencer: PC, branch-target LUT, registered ALU flags, run/halt FSM.
// Define PROG_SEQ_STACK_EN to build the call/return stack (depth S).
module prog_seq #(
    parameter int D         = 12,
    parameter int L         = 5,
    parameter int S         = 4,
    parameter int DONE_ADDR = 128
) (
    input  logic      clk,
    input  logic      reset,
    prog_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int           LUT_N   = 1 << L;
    localparam logic [D-1:0] DONE_PC = D'(DONE_ADDR);

    state_t       state;
    logic [D-1:0] pc;
    logic [D-1:0] pc_inc;
    logic [D-1:0] pc_rel;
    logic [D-1:0] next_pc;
    logic [D-1:0] lut [LUT_N];
    logic         zq, pq, scq;
    logic         busy_q, done_q;
    logic         cond;
    logic         step;

`ifdef PROG_SEQ_STACK_EN
    localparam int SPW = $clog2(S + 1);
    localparam int SIW = (S > 1) ? $clog2(S) : 1;

    logic [D-1:0]   stk [S];
    logic [SPW-1:0] sp;
    logic           err_q;
    logic           do_push, do_pop, set_err;
`endif

    always_comb begin
        step   = (state == RUN) && (pc != DONE_PC);
        pc_inc = pc + D'(1);
        pc_rel = pc + D'($signed(bus.rel_off));
        case (bus.br_cond)
            2'b00:   cond = 1'b1;
            2'b01:   cond = zq;
            2'b10:   cond = ~zq;
            default: cond = pq;
        endcase
        next_pc = pc_inc;
`ifdef PROG_SEQ_STACK_EN
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_err = 1'b0;
        // ret/call outrank branches even when they fault (fault falls back to PC+1)
        if (bus.ret) begin
            if (sp != '0) begin
                do_pop  = step;
                next_pc = stk[SIW'(sp - 1'b1)];
            end else begin
                set_err = step;
            end
        end else if (bus.call) begin
            if (sp != SPW'(S)) begin
                do_push = step;
                next_pc = lut[bus.lut_idx];
            end else begin
                set_err = step;
            end
        end else
`endif
        if (bus.br_abs) begin
            if (cond) next_pc = lut[bus.lut_idx];
        end else if (bus.br_rel && cond) begin
            next_pc = pc_rel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= '0;
            zq     <= 1'b0;
            pq     <= 1'b0;
            scq    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int unsigned i = 0; i < LUT_N; i++) lut[i] <= '0;
`ifdef PROG_SEQ_STACK_EN
            sp    <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pc <= '0;
                    if (bus.lut_we) lut[bus.lut_waddr] <= bus.lut_wdata;
                    if (bus.req) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        zq     <= 1'b0;
                        pq     <= 1'b0;
                        scq    <= 1'b0;
`ifdef PROG_SEQ_STACK_EN
                        sp    <= '0;
                        err_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (!step) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        pc <= next_pc;
                        if (bus.flag_en) begin
                            zq <= bus.zero;
                            pq <= bus.pari;
                        end
                        if (bus.sc_clr)     scq <= 1'b0;
                        else if (bus.sc_en) scq <= bus.sc_o;
`ifdef PROG_SEQ_STACK_EN
                        if (do_push)      sp <= sp + 1'b1;
                        else if (do_pop)  sp <= sp - 1'b1;
                        if (set_err)      err_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    if (!bus.req) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                        pc     <= '0;
                        zq     <= 1'b0;
                        pq     <= 1'b0;
                        scq    <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef PROG_SEQ_STACK_EN
    // Stack storage needs no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) stk[SIW'(sp)] <= pc_inc;
    end

    assign bus.stk_err = err_q;
`else
    assign bus.stk_err = (S < 0);
`endif

    assign bus.prog_ctr = pc;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.zeroQ    = zq;
    assign bus.pariQ    = pq;
    assign bus.sc_q     = scq;
endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_prog_seq;
    localparam int D         = 12;
    localparam int L         = 5;
    localparam int S         = 4;
    localparam int DONE_ADDR = 128;
    localparam int PCMOD     = 1 << D;
    localparam int MI = 0, MR = 1, MD = 2;

    logic clk;
    logic reset;
    int   vectors    = 0;
    int   miscompares = 0;

    prog_seq_if #(.D(D), .L(L)) bus ();

    prog_seq #(.D(D), .L(L), .S(S), .DONE_ADDR(DONE_ADDR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    int ms, mpc, mz, mp, msc, merr;
    int mlut [1 << L];
    int mstk [$];

    function automatic bit mcond(input logic [1:0] c);
        case (c)
            2'b00:   return 1'b1;
            2'b01:   return mz != 0;
            2'b10:   return mz == 0;
            default: return mp != 0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms = MI; mpc = 0; mz = 0; mp = 0; msc = 0; merr = 0;
            mstk.delete();
            foreach (mlut[i]) mlut[i] = 0;
        end else begin
            case (ms)
                MI: begin
                    if (bus.lut_we) mlut[bus.lut_waddr] = int'(bus.lut_wdata);
                    mpc = 0;
                    if (bus.req) begin
                        ms = MR; mz = 0; mp = 0; msc = 0; merr = 0;
                        mstk.delete();
                    end
                end
                MR: begin
                    if (mpc == DONE_ADDR % PCMOD) begin
                        ms = MD;
                    end else begin
                        int  nxt;
                        bit  handled;
                        nxt = (mpc + 1) % PCMOD;
                        handled = 1'b0;
`ifdef PROG_SEQ_STACK_EN
                        if (bus.ret) begin
                            handled = 1'b1;
                            if (mstk.size() > 0) nxt = mstk.pop_back();
                            else merr = 1;
                        end else if (bus.call) begin
                            handled = 1'b1;
                            if (mstk.size() < S) begin
                                mstk.push_back((mpc + 1) % PCMOD);
                                nxt = mlut[bus.lut_idx];
                            end else merr = 1;
                        end
`endif
                        if (!handled && mcond(bus.br_cond)) begin
                            if (bus.br_abs) nxt = mlut[bus.lut_idx];
                            else if (bus.br_rel)
                                nxt = (mpc + int'($signed(bus.rel_off))) & (PCMOD - 1);
                        end
                        if (bus.flag_en) begin mz = bus.zero; mp = bus.pari; end
                        if (bus.sc_clr) msc = 0;
                        else if (bus.sc_en) msc = bus.sc_o;
                        mpc = nxt;
                    end
                end
                default: begin
                    if (!bus.req) begin
                        ms = MI; mpc = 0; mz = 0; mp = 0; msc = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            vectors++;
            if (int'(bus.prog_ctr) != mpc || bus.busy !== (ms == MR) ||
                bus.done !== (ms == MD) || int'(bus.zeroQ) != mz ||
                int'(bus.pariQ) != mp || int'(bus.sc_q) != msc ||
                int'(bus.stk_err) != merr) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t got pc=%0d busy=%b done=%b z=%b p=%b sc=%b err=%b want pc=%0d busy=%0d done=%0d z=%0d p=%0d sc=%0d err=%0d",
                         $time, bus.prog_ctr, bus.busy, bus.done, bus.zeroQ, bus.pariQ,
                         bus.sc_q, bus.stk_err, mpc, ms == MR, ms == MD, mz, mp, msc, merr);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        bus.br_rel = 0; bus.br_abs = 0; bus.br_cond = 2'b00; bus.rel_off = '0;
        bus.lut_idx = '0; bus.call = 0; bus.ret = 0; bus.zero = 0; bus.pari = 0;
        bus.sc_o = 0; bus.flag_en = 0; bus.sc_clr = 0; bus.sc_en = 0;
        bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
    endtask

    task automatic br_abs(input int idx);
        clr_ctl(); bus.br_abs = 1; bus.lut_idx = L'(idx); tick(); clr_ctl();
    endtask

    task automatic br_rel(input int off, input logic [1:0] c);
        clr_ctl(); bus.br_rel = 1; bus.rel_off = 8'(off); bus.br_cond = c; tick(); clr_ctl();
    endtask

    int wr_idx [7] = '{3, 7, 1, 2, 4, 5, 9};
    int wr_val [7] = '{40, 4090, 20, 30, 60, 70, 100};

    initial begin
        reset = 1'b1;
        bus.req = 0;
        clr_ctl();
        #3 reset = 1'b0;
        #4;
        chk("rst_pc", int'(bus.prog_ctr), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_flags", int'({bus.zeroQ, bus.pariQ, bus.sc_q, bus.stk_err}), 0);
        @(negedge clk) reset = 1'b1;

        // LUT loads in IDLE; the last one shares its edge with IDLE->RUN
        for (int i = 0; i < 7; i++) begin
            bus.lut_we = 1; bus.lut_waddr = L'(wr_idx[i]); bus.lut_wdata = D'(wr_val[i]);
            bus.req = (i == 6);
            tick();
        end
        clr_ctl();
        chk("req_busy", int'(bus.busy), 1);
        chk("first_pc", int'(bus.prog_ctr), 0);
        for (int i = 0; i < 5; i++) tick();
        chk("pc_count5", int'(bus.prog_ctr), 5);

        bus.br_abs = 1; bus.lut_idx = 3; bus.lut_we = 1; bus.lut_waddr = 3; bus.lut_wdata = 99;
        tick(); clr_ctl();
        chk("br_abs_40", int'(bus.prog_ctr), 40);
        br_rel(-30, 2'b00);
        chk("br_rel_back", int'(bus.prog_ctr), 10);
        bus.flag_en = 1; bus.zero = 1; tick(); clr_ctl();
        chk("zeroQ_set", int'(bus.zeroQ), 1);
        br_rel(-4, 2'b01);
        chk("br_rel_zq", int'(bus.prog_ctr), 7);
        br_rel(4, 2'b00);
        br_rel(-4, 2'b10);
        chk("br_rel_nzq", int'(bus.prog_ctr), 12);
        br_abs(9);
        chk("lut_same_edge", int'(bus.prog_ctr), 100);
        bus.sc_en = 1; bus.sc_o = 1; tick();
        chk("sc_load", int'(bus.sc_q), 1);
        bus.sc_clr = 1; tick(); clr_ctl();
        chk("sc_clr_wins", int'(bus.sc_q), 0);
        br_abs(7);
        chk("br_abs_high", int'(bus.prog_ctr), 4090);
        br_rel(10, 2'b00);
        chk("pc_wrap", int'(bus.prog_ctr), 4);
        br_abs(3);
        chk("lut_run_wr_ignored", int'(bus.prog_ctr), 40);
        bus.flag_en = 1; bus.pari = 1; tick(); clr_ctl();
        br_rel(20, 2'b11);
        chk("br_rel_pq", int'(bus.prog_ctr), 61);

`ifdef PROG_SEQ_STACK_EN
        begin
            int tgt [5] = '{1, 2, 4, 5, 1};
            int expc [5] = '{20, 30, 60, 70, 71};
            int rpc [4] = '{61, 31, 21, 62};
            for (int i = 0; i < 5; i++) begin
                bus.call = 1; bus.lut_idx = L'(tgt[i]); tick(); clr_ctl();
                chk("call_pc", int'(bus.prog_ctr), expc[i]);
            end
            chk("stk_overflow", int'(bus.stk_err), 1);
            for (int i = 0; i < 4; i++) begin
                bus.ret = 1; bus.call = (i == 0); bus.lut_idx = 2; tick(); clr_ctl();
                chk("ret_pc", int'(bus.prog_ctr), rpc[i]);
            end
            bus.ret = 1; tick(); clr_ctl();
            chk("ret_empty_pc", int'(bus.prog_ctr), 63);
            chk("stk_err_sticky", int'(bus.stk_err), 1);
        end
`else
        bus.call = 1; bus.lut_idx = 1; tick(); clr_ctl();
        chk("call_noop", int'(bus.prog_ctr), 62);
        bus.ret = 1; tick(); clr_ctl();
        chk("ret_noop", int'(bus.prog_ctr), 63);
        chk("stk_err_tied", int'(bus.stk_err), 0);
`endif

        for (int n = 0; n < 200 && bus.prog_ctr != D'(DONE_ADDR); n++) tick();
        chk("reach_done_pc", int'(bus.prog_ctr), DONE_ADDR);
        chk("done_not_yet", int'(bus.done), 0);
        bus.call = 1; bus.br_abs = 1; bus.flag_en = 1; bus.zero = 0; tick(); clr_ctl();
        chk("done_set", int'(bus.done), 1);
        chk("done_busy", int'(bus.busy), 0);
        chk("done_pc_hold", int'(bus.prog_ctr), DONE_ADDR);
        chk("done_flags_ignored", int'(bus.zeroQ), 0);
        tick();
        chk("done_stays", int'(bus.done), 1);
        bus.req = 0; tick();
        chk("idle_done", int'(bus.done), 0);
        chk("idle_pc", int'(bus.prog_ctr), 0);

        // Asynchronous reset in the middle of a run
        bus.req = 1; tick();
        for (int n = 0; n < 100 && bus.prog_ctr != 50; n++) tick();
        chk("pc_50", int'(bus.prog_ctr), 50);
        bus.flag_en = 1; bus.zero = 1; bus.pari = 1; bus.sc_en = 1; bus.sc_o = 1;
        tick(); clr_ctl();
        #2 reset = 1'b0;
        #1;
        chk("async_pc", int'(bus.prog_ctr), 0);
        chk("async_busy", int'(bus.busy), 0);
        chk("async_flags", int'({bus.zeroQ, bus.pariQ, bus.sc_q}), 0);
        @(negedge clk) reset = 1'b1;
        tick();
        br_abs(3);
        chk("lut_cleared", int'(bus.prog_ctr), 0);

        // Randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            bus.req       = ($urandom_range(9) != 0);
            bus.ret       = ($urandom_range(19) == 0);
            bus.call      = ($urandom_range(14) == 0);
            bus.br_abs    = ($urandom_range(9) == 0);
            bus.br_rel    = ($urandom_range(7) == 0);
            bus.br_cond   = 2'($urandom_range(3));
            bus.rel_off   = 8'($urandom_range(16) + 248);
            bus.lut_idx   = L'($urandom_range((1 << L) - 1));
            bus.zero      = 1'($urandom_range(1));
            bus.pari      = 1'($urandom_range(1));
            bus.sc_o      = 1'($urandom_range(1));
            bus.flag_en   = ($urandom_range(3) == 0);
            bus.sc_clr    = ($urandom_range(7) == 0);
            bus.sc_en     = ($urandom_range(3) == 0);
            bus.lut_we    = ($urandom_range(2) == 0);
            bus.lut_waddr = L'($urandom_range((1 << L) - 1));
            bus.lut_wdata = D'($urandom_range(140));
            if ($urandom_range(399) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick();
        end
        clr_ctl();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
